q_mult: RTL and testbench
=========================

Name: q_mult

Overview:
- Pipelined signed two's-complement N x N multiplier with a valid/end side channel.
- Used per input channel inside the pointwise-convolution unit: one instance per channel, all fed the same input_vld.
- The parent unit sums the products only when every instance's product_dout_vld is high in the same cycle, so latency must be fixed and data-independent.

Parameters:
- N, 16: bit width of each operand; the product is 2N bits.

Ports:
- clk  in  1  clock; all logic is rising-edge.
- rst_n  in  1  reset; synchronous, active-low.
- input_vld  in  1  operands on this cycle are valid.
- multiplicand_din  in  N  signed two's-complement operand A.
- multiplier_din  in  N  signed two's-complement operand B.
- product_dout  out  2N  signed full-precision product A*B.
- product_dout_vld  out  1  product_dout is valid this cycle.
- product_end  out  1  one-cycle pulse marking the end of a valid output burst.

Behaviour:
- Reset: when rst_n=0 at a rising edge, clear all pipeline registers.
  - product_dout=0, product_dout_vld=0, product_end=0.
  - A burst in flight is discarded; no product_end pulse is produced for it.
- Pipeline: two register stages, fixed latency of 2 cycles.
  - Edge k: sample the operands and input_vld into stage 1.
  - Edge k+1: register the stage-1 product into stage 2, which drives the outputs.
  - Result: product_dout_vld is high in cycle k+2 exactly when input_vld was high in cycle k.
  - Throughput: one product per cycle; back-to-back valid inputs give back-to-back valid outputs.
- No stall or backpressure; input_vld is the only handshake.
- Operands are sampled only when input_vld=1.
  - When input_vld=0, the stage-1 valid is cleared.
  - When product_dout_vld=0, product_dout must read 0, never stale data.
- Arithmetic: product_dout = signed(A) * signed(B), full 2N bits, no rounding or truncation.
  - Bit 2N-1 is the sign bit, so the parent may sign-extend from it.
  - No overflow is possible: the extreme case (-2^(N-1))*(-2^(N-1)) = 2^(2N-2) is exactly representable (0x40000000 for N=16).
- product_end is registered and pulses for one cycle in the cycle right after the last valid output, i.e. where product_dout_vld goes 1 to 0.
  - A one-cycle input gap inside a burst produces a product_end pulse in that gap.
  - product_end and product_dout_vld are never high in the same cycle.
- Any X on the operands while input_vld=0 must not propagate to the outputs.

Optional Feature:
- Macro: QMULT_OUT_REG_EN.
- When defined: add a third output register stage after the product register.
  - Latency becomes 3 cycles; product_dout_vld and product_end shift one cycle later.
  - All other rules are unchanged.
- When undefined: latency is 2 cycles as specified above.
- All instances in a parent must be built with the same setting.

Decomposition:
- Shared package: localparam for the base latency (2), and a function returning the effective latency under QMULT_OUT_REG_EN for parent alignment logic.
- One natural sub-module, q_mult_vld_pipe: a parameterized valid-delay shift register that also generates the falling-edge product_end pulse.
- The datapath stays inline in q_mult.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles while driving input_vld=1, A=5, B=7.
  - All outputs stay 0; after release, the first product 35 appears exactly 2 cycles later.
- Single valid: A=3, B=-4 for one cycle.
  - Two cycles later: product_dout=0xFFFFFFF4 (-12), product_dout_vld=1 for one cycle.
  - product_end=1 on the following cycle; product_dout=0 when not valid.
- Extremes:
  - A=-32768, B=-32768 gives 0x40000000.
  - A=-32768, B=32767 gives 0xC0008000.
  - A=32767, B=32767 gives 0x3FFF0001.
- Streaming: 8 back-to-back random operand pairs.
  - Eight consecutive correct products with vld high continuously, then a single end pulse after the eighth.
- Gapped stream: valid pattern 1,1,0,1 on the input.
  - Output vld pattern 1,1,0,1 delayed by 2 cycles; end pulses land in the gap cycle and after the final product.
- Reset mid-burst: assert rst_n=0 while products are in flight.
  - Outputs go 0 on the next edge and no product_end pulse appears.
  - Repeat with QMULT_OUT_REG_EN defined and check 3-cycle latency.

Source files
------------

// File: rtl/q_mult_pkg.sv
// rtl/q_mult_pkg.sv - latency constants shared by q_mult and its parent alignment logic
// QMULT_OUT_REG_EN adds one output register stage to every q_mult instance.
package q_mult_pkg;

  localparam int QM_BASE_LATENCY = 2;

  // Parents use this to align side channels with product_dout_vld.
  function automatic int qm_latency();
`ifdef QMULT_OUT_REG_EN
    return QM_BASE_LATENCY + 1;
`else
    return QM_BASE_LATENCY;
`endif
  endfunction

endpackage

// File: rtl/q_mult_vld_pipe.sv
// rtl/q_mult_vld_pipe.sv - valid delay line with registered end-of-burst pulse
// End pulses in the cycle where the delayed valid falls from 1 to 0.
module q_mult_vld_pipe #(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_vld,
  output logic o_vld,
  output logic o_end
);

  logic [DEPTH-1:0] r_shift;
  logic             r_end;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_shift <= '0;
      r_end   <= 1'b0;
    end else begin
      r_shift <= {r_shift[DEPTH-2:0], i_vld};
      // Output valid about to drop: the tap feeding it is empty.
      r_end   <= r_shift[DEPTH-1] & ~r_shift[DEPTH-2];
    end
  end

  assign o_vld = r_shift[DEPTH-1];
  assign o_end = r_end;

endmodule

// File: rtl/q_mult.sv
// rtl/q_mult.sv - pipelined signed N x N multiplier with valid/end side channel
// Latency 2 cycles; 3 cycles when QMULT_OUT_REG_EN is defined.
module q_mult
  import q_mult_pkg::*;
#(
  parameter int N = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  input_vld,
  input  logic signed [N-1:0]   multiplicand_din,
  input  logic signed [N-1:0]   multiplier_din,
  output logic signed [2*N-1:0] product_dout,
  output logic                  product_dout_vld,
  output logic                  product_end
);

  localparam int LAT = qm_latency();

  logic signed [N-1:0]   r_a;
  logic signed [N-1:0]   r_b;
  logic signed [2*N-1:0] w_prod;
  logic signed [2*N-1:0] r_prod;

  // Invalid cycles load zero operands, so idle outputs read 0 and X cannot leak.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_a    <= '0;
      r_b    <= '0;
      r_prod <= '0;
    end else begin
      r_a    <= input_vld ? multiplicand_din : '0;
      r_b    <= input_vld ? multiplier_din   : '0;
      r_prod <= w_prod;
    end
  end

  assign w_prod = r_a * r_b;

`ifdef QMULT_OUT_REG_EN
  logic signed [2*N-1:0] r_prod_out;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_prod_out <= '0;
    end else begin
      r_prod_out <= r_prod;
    end
  end

  assign product_dout = r_prod_out;
`else
  assign product_dout = r_prod;
`endif

  q_mult_vld_pipe #(
    .DEPTH (LAT)
  ) u_vld_pipe (
    .clk   (clk),
    .rst_n (rst_n),
    .i_vld (input_vld),
    .o_vld (product_dout_vld),
    .o_end (product_end)
  );

endmodule

// File: tb/tb_q_mult.sv
// tb/tb_q_mult.sv - directed self-checking bench for q_mult
// Latency follows qm_latency(), so the bench also covers QMULT_OUT_REG_EN builds.
module tb_q_mult;
  import q_mult_pkg::*;

  localparam int N   = 16;
  localparam int LAT = qm_latency();
  localparam int MAXC = 256;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic                  input_vld;
  logic signed [N-1:0]   multiplicand_din;
  logic signed [N-1:0]   multiplier_din;
  logic signed [2*N-1:0] product_dout;
  logic                  product_dout_vld;
  logic                  product_end;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic        hv [MAXC];
  logic [31:0] hp [MAXC];

  q_mult #(.N(N)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .input_vld        (input_vld),
    .multiplicand_din (multiplicand_din),
    .multiplier_din   (multiplier_din),
    .product_dout     (product_dout),
    .product_dout_vld (product_dout_vld),
    .product_end      (product_end)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
    end
  endtask

  // One cycle: drive inputs, check outputs against history, record the expected product.
  task automatic step(input logic r, input logic v, input logic [N-1:0] a,
                      input logic [N-1:0] b, input logic [31:0] exp_prod);
    logic        ev, ev_prev, ee;
    logic [31:0] ep;
    rst_n            = r;
    input_vld        = v;
    multiplicand_din = a;
    multiplier_din   = b;
    @(negedge clk);
    ev      = (cyc >= LAT)     ? hv[cyc-LAT]   : 1'b0;
    ep      = (cyc >= LAT)     ? hp[cyc-LAT]   : 32'h0;
    ev_prev = (cyc >= LAT + 1) ? hv[cyc-LAT-1] : 1'b0;
    ee      = ev_prev & ~ev;
    check("vld",  {31'h0, product_dout_vld}, {31'h0, ev});
    check("end",  {31'h0, product_end},      {31'h0, ee});
    check("prod", product_dout,              ep);
    hv[cyc] = r & v;
    hp[cyc] = (r & v) ? exp_prod : 32'h0;
    if (!r) begin
      for (int j = 0; j <= cyc; j++) begin
        hv[j] = 1'b0;
        hp[j] = 32'h0;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 'x, 'x, 32'h0);
  endtask

  initial begin
    logic [N-1:0] ra, rb;
    logic signed [31:0] rp;
    for (int i = 0; i < MAXC; i++) begin
      hv[i] = 1'b0;
      hp[i] = 32'h0;
    end
    rst_n            = 1'b0;
    input_vld        = 1'b1;
    multiplicand_din = 16'sd5;
    multiplier_din   = 16'sd7;
    @(posedge clk);
    #1;

    // Reset held with valid operands, then the first product 35
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 16'd5, 16'd7, 32'd35);
    step(1'b1, 1'b1, 16'd5, 16'd7, 32'd35);
    idle(LAT + 2);

    // Single valid: 3 * -4
    step(1'b1, 1'b1, 16'd3, 16'hFFFC, 32'hFFFF_FFF4);
    idle(LAT + 2);

    // Extremes back to back
    step(1'b1, 1'b1, 16'h8000, 16'h8000, 32'h4000_0000);
    step(1'b1, 1'b1, 16'h8000, 16'h7FFF, 32'hC000_8000);
    step(1'b1, 1'b1, 16'h7FFF, 16'h7FFF, 32'h3FFF_0001);
    step(1'b1, 1'b1, 16'hFFFF, 16'hFFFF, 32'h0000_0001);
    step(1'b1, 1'b1, 16'h0000, 16'h8000, 32'h0000_0000);
    idle(LAT + 2);

    // Streaming: 8 random pairs
    for (int i = 0; i < 8; i++) begin
      ra = N'($urandom);
      rb = N'($urandom);
      rp = $signed(ra) * $signed(rb);
      step(1'b1, 1'b1, ra, rb, rp);
    end
    idle(LAT + 2);

    // Gapped stream 1,1,0,1
    step(1'b1, 1'b1, 16'd10,    16'd20,    32'd200);
    step(1'b1, 1'b1, 16'hFFF6,  16'd20,    32'hFFFF_FF38);
    step(1'b1, 1'b0, 'x,        'x,        32'h0);
    step(1'b1, 1'b1, 16'd100,   16'hFF9C,  32'hFFFF_D8F0);
    idle(LAT + 2);

    // Reset mid-burst: products in flight are dropped without an end pulse
    step(1'b1, 1'b1, 16'd2, 16'd3, 32'd6);
    step(1'b1, 1'b1, 16'd4, 16'd5, 32'd20);
    step(1'b1, 1'b1, 16'd6, 16'd7, 32'd42);
    step(1'b0, 1'b1, 16'd8, 16'd9, 32'd72);
    idle(LAT + 3);

    // Post-reset recovery
    step(1'b1, 1'b1, 16'd1234, 16'd2, 32'd2468);
    idle(LAT + 2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
